// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the CPU control sequencer: FSM state encoding and decoded instruction class.
package cpu_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH      = 4'd1,
    FETCH_WAIT = 4'd2,
    DECODE     = 4'd3,
    EXEC       = 4'd4,
    MUL_WAIT   = 4'd5,
    MEM_ADDR   = 4'd6,
    MEM_WAIT   = 4'd7,
    PC_INC     = 4'd8,
    FAULT      = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    DP  = 2'd0,
    MUL = 2'd1,
    LDR = 2'd2,
    STR = 2'd3
  } instr_class_t;

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Saturating wait counter with clear/increment and an equality match against a target.
module seq_wait_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] target,
  output logic             match
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    match = (count == target);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM generating processing-unit strobes and memory handshake.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       mem_ready,
  input  logic [1:0] instr_class,
  input  logic       cond_pass,
  input  logic       set_flags,
  output logic       mem_read,
  output logic       mem_write,
  output logic       address_latch_trigger,
  output logic       ir_latch_trigger,
  output logic       pc_increment_trigger,
  output logic       reg_write_enable,
  output logic       flags_write_enable,
  output logic       mul_start,
  output logic       busy,
  output logic       fault,
  output logic [3:0] state
);

  localparam int unsigned MAX_WAIT = (MUL_LATENCY > MEM_TIMEOUT) ? MUL_LATENCY : MEM_TIMEOUT;
  localparam int unsigned CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MUL_TGT = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] MEM_TGT = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);
  localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t       cur, nxt;
  instr_class_t cls;
  logic         t_clear, t_inc, t_match;
  logic [CW-1:0] t_target;

  seq_wait_timer #(.WIDTH(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (t_clear),
    .inc    (t_inc),
    .target (t_target),
    .match  (t_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= IDLE;
      cls <= DP;
    end else begin
      cur <= nxt;
      if (cur == DECODE) cls <= instr_class_t'(instr_class);
    end
  end

  always_comb begin
    nxt                   = cur;
    t_clear               = 1'b0;
    t_inc                 = 1'b0;
    t_target              = (cur == MUL_WAIT) ? MUL_TGT : MEM_TGT;
    mem_read              = 1'b0;
    mem_write             = 1'b0;
    address_latch_trigger = 1'b0;
    ir_latch_trigger      = 1'b0;
    pc_increment_trigger  = 1'b0;
    reg_write_enable      = 1'b0;
    flags_write_enable    = 1'b0;
    mul_start             = 1'b0;
    unique case (cur)
      IDLE: if (run) nxt = FETCH;
      FETCH: begin
        address_latch_trigger = 1'b1;
        t_clear               = 1'b1;
        nxt                   = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_latch_trigger = 1'b1;
          nxt              = DECODE;
        end else begin
          t_inc = 1'b1;
          if (TIMEOUT_EN && t_match) nxt = FAULT;
        end
      end
      DECODE: begin
        if (!cond_pass) begin
          nxt = PC_INC;
        end else begin
          unique case (instr_class_t'(instr_class))
            DP:  nxt = EXEC;
            MUL: begin
              mul_start = 1'b1;
              t_clear   = 1'b1;
              nxt       = MUL_WAIT;
            end
            default: nxt = MEM_ADDR;
          endcase
        end
      end
      EXEC: begin
        reg_write_enable   = 1'b1;
        flags_write_enable = set_flags;
        nxt                = PC_INC;
      end
      MUL_WAIT: begin
        t_inc = 1'b1;
        if (t_match) begin
          reg_write_enable   = 1'b1;
          flags_write_enable = set_flags;
          nxt                = PC_INC;
        end
      end
      MEM_ADDR: begin
        address_latch_trigger = 1'b1;
        t_clear               = 1'b1;
        nxt                   = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_write = (cls == STR);
        mem_read  = (cls != STR);
        if (mem_ready) begin
          reg_write_enable = (cls == LDR);
          nxt              = PC_INC;
        end else begin
          t_inc = 1'b1;
          if (TIMEOUT_EN && t_match) nxt = FAULT;
        end
      end
      PC_INC: begin
        pc_increment_trigger = 1'b1;
        nxt                  = run ? FETCH : IDLE;
      end
      FAULT: nxt = FAULT;
      default: nxt = IDLE;
    endcase
    // Reset abandons any in-flight transaction immediately, not at the next edge.
    if (reset) begin
      mem_read              = 1'b0;
      mem_write             = 1'b0;
      address_latch_trigger = 1'b0;
      ir_latch_trigger      = 1'b0;
      pc_increment_trigger  = 1'b0;
      reg_write_enable      = 1'b0;
      flags_write_enable    = 1'b0;
      mul_start             = 1'b0;
    end
  end

  always_comb begin
    state = cur;
    busy  = (cur != IDLE) && (cur != FAULT);
    fault = (cur == FAULT);
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations, a negedge monitor pops and compares.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset, run, mem_ready, cond_pass, set_flags;
  logic [1:0] instr_class;
  logic       mem_read, mem_write, address_latch_trigger, ir_latch_trigger;
  logic       pc_increment_trigger, reg_write_enable, flags_write_enable, mul_start;
  logic       busy, fault;
  logic [3:0] state;

  cpu_sequencer #(.MUL_LATENCY(2), .MEM_TIMEOUT(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .run                   (run),
    .mem_ready             (mem_ready),
    .instr_class           (instr_class),
    .cond_pass             (cond_pass),
    .set_flags             (set_flags),
    .mem_read              (mem_read),
    .mem_write             (mem_write),
    .address_latch_trigger (address_latch_trigger),
    .ir_latch_trigger      (ir_latch_trigger),
    .pc_increment_trigger  (pc_increment_trigger),
    .reg_write_enable      (reg_write_enable),
    .flags_write_enable    (flags_write_enable),
    .mul_start             (mul_start),
    .busy                  (busy),
    .fault                 (fault),
    .state                 (state)
  );

  always #5 clk = ~clk;

  // Strobe bits: {rd, wr, addr_latch, ir_latch, pc_inc, reg_we, flags_we, mul_start}
  localparam logic [7:0] RD = 8'h80, WR = 8'h40, AL = 8'h20, IR = 8'h10;
  localparam logic [7:0] PC = 8'h08, RW = 8'h04, FW = 8'h02, MS = 8'h01;
  localparam logic [7:0] NONE = 8'h00;

  typedef struct {
    string      nm;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic cyc(input string nm, input state_t st, input logic [7:0] stb);
    exp_t e;
    e.nm = nm;
    e.v  = {4'(st), (st != IDLE) && (st != FAULT), st == FAULT, stb};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e   = sb.pop_front();
      act = {state, busy, fault, mem_read, mem_write, address_latch_trigger, ir_latch_trigger,
             pc_increment_trigger, reg_write_enable, flags_write_enable, mul_start};
      checks++;
      if (act === e.v) passed++;
      else $display("FAIL %s: got state=%0d busy=%b fault=%b strobes=%b, expected state=%0d busy=%b fault=%b strobes=%b",
                    e.nm, act[13:10], act[9], act[8], act[7:0], e.v[13:10], e.v[9], e.v[8], e.v[7:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; instr_class = 2'd0;
    cond_pass = 1'b1; set_flags = 1'b1;
    @(posedge clk); #1;
    cyc("reset", IDLE, NONE);

    // DP, S=1, memory immediate
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; instr_class = 2'd0;
    cyc("dp_idle", IDLE, NONE);
    cyc("dp_fetch", FETCH, AL);
    cyc("dp_fwait", FETCH_WAIT, RD | IR);
    cyc("dp_decode", DECODE, NONE);
    cyc("dp_exec", EXEC, RW | FW);
    cyc("dp_pcinc", PC_INC, PC);

    // MUL, S=0
    instr_class = 2'd1; set_flags = 1'b0;
    cyc("mul_fetch", FETCH, AL);
    cyc("mul_fwait", FETCH_WAIT, RD | IR);
    cyc("mul_decode", DECODE, MS);
    cyc("mul_wait1", MUL_WAIT, NONE);
    cyc("mul_wait2", MUL_WAIT, RW);
    cyc("mul_pcinc", PC_INC, PC);

    // LDR with three stalled MEM_WAIT cycles
    instr_class = 2'd2;
    cyc("ldr_fetch", FETCH, AL);
    cyc("ldr_fwait", FETCH_WAIT, RD | IR);
    cyc("ldr_decode", DECODE, NONE);
    cyc("ldr_maddr", MEM_ADDR, AL);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ldr_mwait_stall", MEM_WAIT, RD);
    mem_ready = 1'b1;
    cyc("ldr_mwait_done", MEM_WAIT, RD | RW);
    cyc("ldr_pcinc", PC_INC, PC);

    // STR, condition failed
    instr_class = 2'd3; cond_pass = 1'b0;
    cyc("strn_fetch", FETCH, AL);
    cyc("strn_fwait", FETCH_WAIT, RD | IR);
    cyc("strn_decode", DECODE, NONE);
    cyc("strn_pcinc", PC_INC, PC);

    // STR, condition passed, two stall cycles
    cond_pass = 1'b1;
    cyc("str_fetch", FETCH, AL);
    cyc("str_fwait", FETCH_WAIT, RD | IR);
    cyc("str_decode", DECODE, NONE);
    cyc("str_maddr", MEM_ADDR, AL);
    mem_ready = 1'b0;
    cyc("str_mwait_stall1", MEM_WAIT, WR);
    cyc("str_mwait_stall2", MEM_WAIT, WR);
    mem_ready = 1'b1;
    cyc("str_mwait_done", MEM_WAIT, WR);
    cyc("str_pcinc", PC_INC, PC);

    // run dropped during EXEC: finish, then park
    instr_class = 2'd0; set_flags = 1'b1;
    cyc("park_fetch", FETCH, AL);
    cyc("park_fwait", FETCH_WAIT, RD | IR);
    cyc("park_decode", DECODE, NONE);
    run = 1'b0;
    cyc("park_exec", EXEC, RW | FW);
    cyc("park_pcinc", PC_INC, PC);
    for (int i = 0; i < 3; i++) cyc("park_idle", IDLE, NONE);

    // reset asserted in MEM_WAIT
    run = 1'b1; instr_class = 2'd2;
    cyc("rst_idle0", IDLE, NONE);
    cyc("rst_fetch", FETCH, AL);
    cyc("rst_fwait", FETCH_WAIT, RD | IR);
    cyc("rst_decode", DECODE, NONE);
    cyc("rst_maddr", MEM_ADDR, AL);
    mem_ready = 1'b0;
    cyc("rst_mwait", MEM_WAIT, RD);
    reset = 1'b1;
    cyc("rst_mwait_in_reset", MEM_WAIT, NONE);
    reset = 1'b0; run = 1'b0;
    cyc("rst_after", IDLE, NONE);

    // fetch timeout: mem_ready stuck low for 16 wait cycles
    run = 1'b1; mem_ready = 1'b0;
    cyc("to_idle", IDLE, NONE);
    cyc("to_fetch", FETCH, AL);
    for (int i = 0; i < 16; i++) cyc("to_fwait", FETCH_WAIT, RD);
    for (int i = 0; i < 50; i++) cyc("to_fault", FAULT, NONE);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; run = 1'b0;
    cyc("to_reset_idle", IDLE, NONE);

    // mem_ready on exactly the 16th wait cycle beats the timeout
    run = 1'b1; instr_class = 2'd0; set_flags = 1'b0;
    cyc("edge_idle", IDLE, NONE);
    cyc("edge_fetch", FETCH, AL);
    for (int i = 0; i < 15; i++) cyc("edge_fwait", FETCH_WAIT, RD);
    mem_ready = 1'b1;
    cyc("edge_fwait16", FETCH_WAIT, RD | IR);
    cyc("edge_decode", DECODE, NONE);
    cyc("edge_exec", EXEC, RW);
    run = 1'b0;
    cyc("edge_pcinc", PC_INC, PC);
    cyc("edge_idle_end", IDLE, NONE);

    @(negedge clk); #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Control FSM that drives the processing unit through the fetch/decode/execute cycle. Generates the processing unit's strobes: pc_increment_trigger, ir_latch_trigger and address_latch_trigger. Also generates the register-bank write enable, the multiplier start and the memory read/write handshake. Sits beside the processing unit in the CPU top; consumes decoder outputs (instruction class, condition pass, S bit) and the memory ready signal.

Parameters:
MUL_LATENCY, 2, cycles from mul_start until the multiplier result is valid (>=1)
MEM_TIMEOUT, 16, max wait cycles for mem_ready before fault; 0 disables timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  enable sequencing; sampled in IDLE and PC_INC
mem_ready  in  1  memory read data valid / write accepted
instr_class  in  2  from decoder: 0 DP, 1 MUL, 2 LDR, 3 STR
cond_pass  in  1  instruction condition satisfied by current NZVC
set_flags  in  1  instruction S bit
mem_read  out  1  memory read request
mem_write  out  1  memory write request
address_latch_trigger  out  1  load address_reg (PC in FETCH, ALU result in MEM_ADDR)
ir_latch_trigger  out  1  latch din into IR
pc_increment_trigger  out  1  advance PC by 4
reg_write_enable  out  1  register bank write strobe
flags_write_enable  out  1  NZVC update strobe
mul_start  out  1  apply operands to multiplier
busy  out  1  state != IDLE and state != FAULT
fault  out  1  sticky memory-timeout fault
state  out  4  current state encoding, for debug

Behaviour:
- All strobes are combinational from the state register plus mem_ready/run/decoder inputs. They are single-cycle unless stated otherwise, and are forced to 0 while reset=1.
- Reset: state=IDLE, wait counter=0, latched class=DP, fault=0, all outputs 0.
- IDLE: no strobes; run=1 -> FETCH.
- FETCH: address_latch_trigger=1 -> FETCH_WAIT; wait counter cleared.
- FETCH_WAIT: mem_read=1 every cycle.
  - mem_ready=1: ir_latch_trigger=1 -> DECODE.
  - Otherwise: counter++.
- DECODE: capture instr_class into the latched-class register (instr_class and cond_pass are sampled only here). Transitions:
  - cond_pass=0 -> PC_INC (no side effects).
  - DP -> EXEC.
  - MUL -> MUL_WAIT, with mul_start=1 this cycle and counter cleared.
  - LDR/STR -> MEM_ADDR.
- EXEC: reg_write_enable=1, flags_write_enable=set_flags -> PC_INC.
- MUL_WAIT: counter++ each cycle. On the MUL_LATENCY-th cycle: reg_write_enable=1, flags_write_enable=set_flags -> PC_INC.
- MEM_ADDR: address_latch_trigger=1 -> MEM_WAIT; counter cleared.
- MEM_WAIT: mem_read=1 (latched LDR) or mem_write=1 (latched STR), held every cycle until mem_ready. Same-cycle mem_ready for LDR: reg_write_enable=1. Then -> PC_INC.
- PC_INC: pc_increment_trigger=1; run=1 -> FETCH, else -> IDLE.
- FAULT: fault=1, all strobes 0, busy=0. Only reset exits.
- Timeout: in FETCH_WAIT/MEM_WAIT, when MEM_TIMEOUT!=0 and the MEM_TIMEOUT-th consecutive wait cycle sees mem_ready=0, next state is FAULT. mem_ready arriving on exactly that cycle wins over the timeout.
- Counter width is clog2(max(MUL_LATENCY, MEM_TIMEOUT)+1). It saturates and never wraps.
- run deasserted mid-instruction: the instruction completes; the sequencer parks after PC_INC. run is ignored outside IDLE/PC_INC.
- Reset mid-instruction: no further strobes; IDLE on the next cycle. Partial memory transaction is abandoned.
- Cycle counts with mem_ready immediate:
  - DP: 5.
  - MUL: 4+MUL_LATENCY.
  - LDR/STR: 6.
  - Failed condition: 4.

Decomposition:
- Package cpu_pkg: state enum (IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, MUL_WAIT, MEM_ADDR, MEM_WAIT, PC_INC, FAULT; 4-bit encoding) and instr_class enum (DP, MUL, LDR, STR).
- One sub-module, seq_wait_timer: clear/increment saturating counter with a match output. Shared between multiplier latency and memory timeout.

Test Plan:
1. Reset, run=1, mem_ready=1, DP, cond_pass=1, set_flags=1 -> address_latch c1, ir_latch c2, reg_we+flags_we c4, pc_inc c5, address_latch c6.
2. MUL, MUL_LATENCY=2, set_flags=0 -> mul_start c3, reg_we c5 only, flags_we never, pc_inc c6.
3. LDR with mem_ready low for 3 MEM_WAIT cycles -> mem_read held 4 cycles, reg_we on the 4th, pc_inc next cycle, 9 cycles total.
4. STR with cond_pass=0 -> no mem_write, no reg_we, no address_latch after c1, pc_inc c4. STR with cond_pass=1 -> mem_write held until mem_ready, reg_we never.
5. mem_ready stuck low in FETCH_WAIT, MEM_TIMEOUT=16 -> FAULT after the 16th wait cycle; fault=1, busy=0, no strobes for 50 cycles; reset -> IDLE, fault=0. Repeat with mem_ready on the 16th cycle -> no fault.
6. run dropped during EXEC -> pc_inc, then IDLE with no further strobes. Reset asserted in MEM_WAIT -> mem_read=0 that cycle, IDLE next cycle.
